// File: rtl/hash_sched_pkg.sv
// Shared types and constants for the hash_data job scheduler and its arbiter.
package hash_sched_pkg;

    localparam int ADDR_W_DEF         = 11;
    localparam int DATA_W_DEF         = 13;
    localparam int DEG_W_DEF          = 11;
    localparam int START_WAIT_DEF     = 4;
    localparam int TIMEOUT_CYCLES_DEF = 8192;

    localparam int NUM_REQ  = 2;
    localparam int REQ_ENC  = 0;
    localparam int REQ_CONF = 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_RUN       = 3'd3,
        ST_FINISH    = 3'd4
    } sched_state_t;

endpackage

// File: rtl/hash_job_scheduler_if.sv
// Requester, engine and bank signals of the scheduler; master = scheduler side.
interface hash_job_scheduler_if
    import hash_sched_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEG_W  = DEG_W_DEF
) ();

    logic [NUM_REQ-1:0] req;
    logic [DEG_W-1:0]   req_degp0;
    logic [DEG_W-1:0]   req_degp1;
    logic [NUM_REQ-1:0] done;
    logic [NUM_REQ-1:0] err;
    logic [NUM_REQ-1:0] grant;
    logic               eng_start;
    logic [DEG_W-1:0]   eng_degp;
    logic               eng_busy;
    logic [ADDR_W-1:0]  eng_mem_addr;
    logic [DATA_W-1:0]  eng_mem_data;
    logic [ADDR_W-1:0]  bank_addr;
    logic [NUM_REQ-1:0] bank_en;
    logic [DATA_W-1:0]  bank_data0;
    logic [DATA_W-1:0]  bank_data1;

    modport master (
        input  req, req_degp0, req_degp1, eng_busy, eng_mem_addr, bank_data0, bank_data1,
        output done, err, grant, eng_start, eng_degp, eng_mem_data, bank_addr, bank_en
    );

    modport slave (
        output req, req_degp0, req_degp1, eng_busy, eng_mem_addr, bank_data0, bank_data1,
        input  done, err, grant, eng_start, eng_degp, eng_mem_data, bank_addr, bank_en
    );

endinterface

// File: rtl/hash_rr_arbiter2.sv
// Two-way round-robin pick; on a tie the requester that did not own the last job wins.
module hash_rr_arbiter2
    import hash_sched_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               update,
    input  logic               owner,
    output logic [NUM_REQ-1:0] pick,
    output logic               pick_valid
);

    logic last_owner_q;
    logic last_owner_d;

    always_comb begin
        last_owner_d = last_owner_q;
        if (update) begin
            last_owner_d = owner;
        end
    end

    // Resetting to the confirm bank lets the encoder win the very first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_owner_q <= 1'(REQ_CONF);
        end else begin
            last_owner_q <= last_owner_d;
        end
    end

    always_comb begin
        pick = '0;
        pick[REQ_ENC]  = req[REQ_ENC]  & (~req[REQ_CONF] | (last_owner_q == 1'(REQ_CONF)));
        pick[REQ_CONF] = req[REQ_CONF] & (~req[REQ_ENC]  | (last_owner_q == 1'(REQ_ENC)));
    end

    assign pick_valid = |req;

endmodule

// File: rtl/hash_job_scheduler.sv
// Grants the shared hash_data engine to one of two requesters and muxes its bank.
// Build option: define HASH_SCHED_TIMEOUT_EN for the RUN watchdog that aborts with err.
module hash_job_scheduler
    import hash_sched_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEG_W      = DEG_W_DEF,
    parameter int START_WAIT = START_WAIT_DEF
`ifdef HASH_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hash_job_scheduler_if.master  bus
);

    localparam int WAIT_W = (START_WAIT > 1) ? $clog2(START_WAIT) : 1;

    sched_state_t       state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [DEG_W-1:0]   degp_q, degp_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;

    logic [NUM_REQ-1:0] pick;
    logic               pick_valid;
    logic               arb_update;

`ifdef HASH_SCHED_TIMEOUT_EN
    localparam int RUN_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [NUM_REQ-1:0] err_pulse;
`endif

    hash_rr_arbiter2 u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (bus.req),
        .update     (arb_update),
        .owner      (grant_q[REQ_CONF]),
        .pick       (pick),
        .pick_valid (pick_valid)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        degp_d     = degp_q;
        wait_d     = wait_q;
        arb_update = 1'b0;
`ifdef HASH_SCHED_TIMEOUT_EN
        run_d      = run_q;
        err_pulse  = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick;
                    degp_d  = pick[REQ_CONF] ? bus.req_degp1 : bus.req_degp0;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                wait_d  = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (bus.eng_busy) begin
                    state_d = ST_RUN;
`ifdef HASH_SCHED_TIMEOUT_EN
                    run_d   = '0;
`endif
                end else if (wait_q == WAIT_W'(START_WAIT - 1)) begin
                    // Engine never acknowledged: close it out as a zero-length job.
                    state_d = ST_FINISH;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_RUN: begin
`ifdef HASH_SCHED_TIMEOUT_EN
                if (!bus.eng_busy) begin
                    state_d = ST_FINISH;
                end else if (run_q == RUN_W'(TIMEOUT_CYCLES - 1)) begin
                    err_pulse  = grant_q;
                    grant_d    = '0;
                    arb_update = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    run_d = run_q + 1'b1;
                end
`else
                if (!bus.eng_busy) begin
                    state_d = ST_FINISH;
                end
`endif
            end
            ST_FINISH: begin
                grant_d    = '0;
                arb_update = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            degp_q  <= '0;
            wait_q  <= '0;
`ifdef HASH_SCHED_TIMEOUT_EN
            run_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            degp_q  <= degp_d;
            wait_q  <= wait_d;
`ifdef HASH_SCHED_TIMEOUT_EN
            run_q   <= run_d;
`endif
        end
    end

    // Memory path adds no latency: the engine sees each bank's native read timing.
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  bank_data [NUM_REQ];
    logic [DATA_W-1:0]  data_term [NUM_REQ];
    logic [NUM_REQ-1:0] bank_en_w;

    assign mem_addr            = bus.eng_mem_addr;
    assign bank_data[REQ_ENC]  = bus.bank_data0;
    assign bank_data[REQ_CONF] = bus.bank_data1;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_bank
            assign data_term[gi] = grant_q[gi] ? bank_data[gi] : '0;
            assign bank_en_w[gi] = grant_q[gi] & (state_q != ST_IDLE);
        end
    endgenerate

    assign bus.bank_addr    = mem_addr;
    assign bus.bank_en      = bank_en_w;
    assign bus.eng_mem_data = data_term[REQ_ENC] | data_term[REQ_CONF];

    assign bus.grant     = grant_q;
    assign bus.eng_start = (state_q == ST_LAUNCH);
    assign bus.eng_degp  = degp_q;
    assign bus.done      = (state_q == ST_FINISH) ? grant_q : '0;
`ifdef HASH_SCHED_TIMEOUT_EN
    assign bus.err       = err_pulse;
`else
    assign bus.err       = '0;
`endif

endmodule

// File: tb/tb_hash_job_scheduler.sv
// Scenario bench for hash_job_scheduler with a simple hash_data engine model.
module tb_hash_job_scheduler;
    import hash_sched_pkg::*;

    localparam int AW = 11;
    localparam int DW = 13;
    localparam int GW = 11;
    localparam int SW = 4;
`ifdef HASH_SCHED_TIMEOUT_EN
    localparam int TO = 16;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hash_job_scheduler_if #(.ADDR_W(AW), .DATA_W(DW), .DEG_W(GW)) bus ();

    hash_job_scheduler #(
        .ADDR_W(AW), .DATA_W(DW), .DEG_W(GW), .START_WAIT(SW)
`ifdef HASH_SCHED_TIMEOUT_EN
        , .TIMEOUT_CYCLES(TO)
`endif
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Engine model: 0 = busy for eng_len cycles, 1 = never busy, 2 = stuck busy
    int eng_mode = 0;
    int eng_len  = 1;
    int eng_rem  = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.eng_busy = 1'b0;
            eng_rem      = 0;
        end else if (bus.eng_start === 1'b1 && eng_mode != 1) begin
            bus.eng_busy = 1'b1;
            eng_rem      = eng_len;
        end else if (bus.eng_busy && eng_mode == 0) begin
            if (eng_rem <= 1) bus.eng_busy = 1'b0;
            else eng_rem--;
        end
        bus.eng_mem_addr = bus.eng_busy ? AW'($urandom) : '0;
    end

    // Free-running invariant counters, inspected as deltas by the scenarios
    int mon_grant11 = 0, mon_en_err = 0, mon_addr_err = 0, mon_data_err = 0;
    int mon_starts = 0, mon_err_pulse = 0;
    logic [DW-1:0] mon_exp_data;
    always @(posedge clk) begin
        #3;
        if (bus.grant === 2'b11) mon_grant11++;
        if (bus.bank_en !== bus.grant) mon_en_err++;
        if (bus.bank_addr !== bus.eng_mem_addr) mon_addr_err++;
        case (bus.grant)
            2'b01:   mon_exp_data = bus.bank_data0;
            2'b10:   mon_exp_data = bus.bank_data1;
            default: mon_exp_data = '0;
        endcase
        if (bus.eng_mem_data !== mon_exp_data) mon_data_err++;
        if (bus.eng_start === 1'b1) mon_starts++;
        if (bus.err !== 2'b00) mon_err_pulse++;
    end

    logic [1:0]    exp_start_who[$];
    logic [GW-1:0] exp_start_degp[$];
    logic [1:0]    exp_done_who[$];

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n   = 1'b0;
        bus.req = 2'b00;
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    // kind 0 waits for eng_start, kind 1 waits for done or err
    task automatic wait_for(input int kind, input int budget, output int n,
                            output bit timed_out, output logic last_busy);
        logic prev;
        n = 0;
        timed_out = 1'b1;
        last_busy = 1'b0;
        while (n < budget) begin
            prev = bus.eng_busy;
            cycle();
            n++;
            if ((kind == 0 && bus.eng_start === 1'b1) ||
                (kind == 1 && (bus.done !== 2'b00 || bus.err !== 2'b00))) begin
                timed_out = 1'b0;
                last_busy = prev;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) cycle();
        checks++; if (bus.grant !== 2'b00) begin $display("FAIL reset_grant: got %b want 00", bus.grant); errors++; end
        checks++; if (bus.done !== 2'b00) begin $display("FAIL reset_done: got %b want 00", bus.done); errors++; end
        checks++; if (bus.err !== 2'b00) begin $display("FAIL reset_err: got %b want 00", bus.err); errors++; end
        checks++; if (bus.eng_start !== 1'b0) begin $display("FAIL reset_start: got %b want 0", bus.eng_start); errors++; end
        checks++; if (bus.eng_degp !== '0) begin $display("FAIL reset_degp: got %0d want 0", bus.eng_degp); errors++; end
        checks++; if (bus.bank_en !== 2'b00) begin $display("FAIL reset_bank_en: got %b want 00", bus.bank_en); errors++; end
        rst_n = 1'b1;
        repeat (2) cycle();
        checks++; if (bus.grant !== 2'b00) begin $display("FAIL idle_grant: got %b want 00", bus.grant); errors++; end
        $display("reset: grant=%b done=%b bank_en=%b", bus.grant, bus.done, bus.bank_en);
    endtask

    task automatic test_single_job();
        int n; bit to; logic lb; logic [1:0] ew; logic [GW-1:0] ed;
        int s_starts, s_en, s_err;
        s_starts = mon_starts; s_en = mon_en_err; s_err = mon_err_pulse;
        bus.req_degp0 = 11'd761; bus.req_degp1 = 11'd33;
        eng_mode = 0; eng_len = 761;
        exp_start_who.push_back(2'b01); exp_start_degp.push_back(11'd761);
        exp_done_who.push_back(2'b01);
        bus.req = 2'b01;
        wait_for(0, 10, n, to, lb);
        ew = exp_start_who.pop_front(); ed = exp_start_degp.pop_front();
        checks++; if (to) begin $display("FAIL single_start: got none want start within 10"); errors++; end
        checks++; if (bus.grant !== ew) begin $display("FAIL single_grant: got %b want %b", bus.grant, ew); errors++; end
        checks++; if (bus.eng_degp !== ed) begin $display("FAIL single_degp: got %0d want %0d", bus.eng_degp, ed); errors++; end
        bus.req_degp0 = 11'd100;
        wait_for(1, 1000, n, to, lb);
        ew = exp_done_who.pop_front();
        checks++; if (to) begin $display("FAIL single_done_timeout: got none want done"); errors++; end
        checks++; if (bus.done !== ew) begin $display("FAIL single_done: got %b want %b", bus.done, ew); errors++; end
        checks++; if (!(lb === 1'b1 && bus.eng_busy === 1'b0)) begin $display("FAIL single_done_timing: got busy %b->%b want 1->0", lb, bus.eng_busy); errors++; end
        checks++; if (bus.eng_degp !== 11'd761) begin $display("FAIL single_degp_frozen: got %0d want 761", bus.eng_degp); errors++; end
        $display("job: owner=%b degp=%0d cycles=%0d", bus.done, bus.eng_degp, n);
        bus.req = 2'b00;
        cycle();
        checks++; if (bus.grant !== 2'b00 || bus.done !== 2'b00) begin $display("FAIL single_after: got grant %b done %b want 00 00", bus.grant, bus.done); errors++; end
        checks++; if (mon_starts - s_starts !== 1) begin $display("FAIL single_start_count: got %0d want 1", mon_starts - s_starts); errors++; end
        checks++; if (mon_en_err - s_en !== 0) begin $display("FAIL single_bank_en: got %0d bad cycles want 0", mon_en_err - s_en); errors++; end
        checks++; if (mon_err_pulse - s_err !== 0) begin $display("FAIL single_err: got %0d err cycles want 0", mon_err_pulse - s_err); errors++; end
    endtask

    task automatic test_round_robin();
        int n; bit to; logic lb; logic [1:0] ew; logic [GW-1:0] ed;
        int s_g11;
        apply_reset();
        s_g11 = mon_grant11;
        bus.req_degp0 = 11'd10; bus.req_degp1 = 11'd20;
        eng_mode = 0; eng_len = 6;
        exp_start_who.push_back(2'b01); exp_start_degp.push_back(11'd10); exp_done_who.push_back(2'b01);
        exp_start_who.push_back(2'b10); exp_start_degp.push_back(11'd20); exp_done_who.push_back(2'b10);
        exp_start_who.push_back(2'b01); exp_start_degp.push_back(11'd10); exp_done_who.push_back(2'b01);
        bus.req = 2'b11;
        for (int j = 0; j < 3; j++) begin
            wait_for(0, 20, n, to, lb);
            ew = exp_start_who.pop_front(); ed = exp_start_degp.pop_front();
            checks++; if (to || bus.grant !== ew) begin $display("FAIL rr_grant%0d: got %b want %b", j, bus.grant, ew); errors++; end
            checks++; if (bus.eng_degp !== ed) begin $display("FAIL rr_degp%0d: got %0d want %0d", j, bus.eng_degp, ed); errors++; end
            wait_for(1, 40, n, to, lb);
            ew = exp_done_who.pop_front();
            checks++; if (to || bus.done !== ew) begin $display("FAIL rr_done%0d: got %b want %b", j, bus.done, ew); errors++; end
            $display("job: owner=%b cycles=%0d", bus.done, n);
            if (j == 2) bus.req = 2'b00;
        end
        cycle();
        checks++; if (mon_grant11 - s_g11 !== 0) begin $display("FAIL rr_grant11: got %0d cycles want 0", mon_grant11 - s_g11); errors++; end
    endtask

    task automatic test_bank_mux();
        int n; bit to; logic lb; int bad, en_bad, addr_bad; bit got_done;
        int s_data;
        s_data = mon_data_err;
        bus.bank_data0 = 13'h0555; bus.bank_data1 = 13'h1ABC;
        bus.req_degp1 = 11'd8; eng_mode = 0; eng_len = 8;
        bus.req = 2'b10;
        wait_for(0, 10, n, to, lb);
        checks++; if (to || bus.grant !== 2'b10) begin $display("FAIL mux_grant: got %b want 10", bus.grant); errors++; end
        bad = 0; en_bad = 0; addr_bad = 0; got_done = 1'b0; n = 0;
        while (n < 60) begin
            if (bus.eng_mem_data !== 13'h1ABC) bad++;
            if (bus.bank_en !== 2'b10) en_bad++;
            if (bus.done !== 2'b00) begin got_done = 1'b1; break; end
            @(negedge clk); #1;
            if (bus.bank_addr !== bus.eng_mem_addr) addr_bad++;
            cycle();
            n++;
        end
        checks++; if (!got_done || bus.done !== 2'b10) begin $display("FAIL mux_done: got %b want 10", bus.done); errors++; end
        checks++; if (bad !== 0) begin $display("FAIL mux_data: got %0d bad cycles want 0", bad); errors++; end
        checks++; if (en_bad !== 0) begin $display("FAIL mux_bank_en: got %0d bad cycles want 0", en_bad); errors++; end
        checks++; if (addr_bad !== 0) begin $display("FAIL mux_addr: got %0d bad cycles want 0", addr_bad); errors++; end
        $display("job: owner=%b data=%h cycles=%0d", bus.done, bus.eng_mem_data, n);
        bus.req = 2'b00;
        cycle();
        checks++; if (bus.eng_mem_data !== '0) begin $display("FAIL mux_idle_data: got %h want 0", bus.eng_mem_data); errors++; end
        checks++; if (mon_data_err - s_data !== 0) begin $display("FAIL mux_monitor: got %0d bad cycles want 0", mon_data_err - s_data); errors++; end
    endtask

    task automatic test_no_busy();
        int n; bit to; logic lb;
        eng_mode = 1; bus.req_degp0 = 11'd5;
        bus.req = 2'b01;
        wait_for(0, 10, n, to, lb);
        checks++; if (to || bus.grant !== 2'b01) begin $display("FAIL nobusy_grant: got %b want 01", bus.grant); errors++; end
        wait_for(1, 20, n, to, lb);
        checks++; if (to || n !== SW + 1) begin $display("FAIL nobusy_latency: got %0d want %0d", n, SW + 1); errors++; end
        checks++; if (bus.done !== 2'b01) begin $display("FAIL nobusy_done: got %b want 01", bus.done); errors++; end
        $display("job: owner=%b zero-length cycles=%0d", bus.done, n);
        bus.req = 2'b00;
        cycle();
        checks++; if (bus.grant !== 2'b00 || bus.bank_en !== 2'b00) begin $display("FAIL nobusy_idle: got grant %b en %b want 00 00", bus.grant, bus.bank_en); errors++; end
        cycle();
        checks++; if (bus.eng_start !== 1'b0) begin $display("FAIL nobusy_stay_idle: got start %b want 0", bus.eng_start); errors++; end
        eng_mode = 0;
    endtask

    task automatic test_reset_mid_run();
        int n; bit to; logic lb;
        eng_mode = 0; eng_len = 200; bus.req_degp0 = 11'd200;
        bus.req = 2'b01;
        wait_for(0, 10, n, to, lb);
        repeat (10) cycle();
        checks++; if (bus.grant !== 2'b01 || bus.eng_busy !== 1'b1) begin $display("FAIL midrst_running: got grant %b busy %b want 01 1", bus.grant, bus.eng_busy); errors++; end
        rst_n = 1'b0; bus.req = 2'b00;
        cycle();
        checks++; if (bus.grant !== 2'b00) begin $display("FAIL midrst_grant: got %b want 00", bus.grant); errors++; end
        checks++; if (bus.done !== 2'b00) begin $display("FAIL midrst_done: got %b want 00", bus.done); errors++; end
        checks++; if (bus.bank_en !== 2'b00) begin $display("FAIL midrst_bank_en: got %b want 00", bus.bank_en); errors++; end
        rst_n = 1'b1;
        bus.req_degp1 = 11'd7; eng_len = 7;
        bus.req = 2'b10;
        wait_for(0, 10, n, to, lb);
        checks++; if (to || bus.grant !== 2'b10) begin $display("FAIL midrst_new_grant: got %b want 10", bus.grant); errors++; end
        checks++; if (bus.eng_degp !== 11'd7) begin $display("FAIL midrst_new_degp: got %0d want 7", bus.eng_degp); errors++; end
        wait_for(1, 40, n, to, lb);
        checks++; if (to || bus.done !== 2'b10) begin $display("FAIL midrst_new_done: got %b want 10", bus.done); errors++; end
        $display("job: owner=%b after reset cycles=%0d", bus.done, n);
        bus.req = 2'b00;
        cycle();
    endtask

`ifdef HASH_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int n; bit to; logic lb;
        eng_mode = 2; bus.req_degp0 = 11'd50; bus.req_degp1 = 11'd9;
        bus.req = 2'b01;
        wait_for(0, 10, n, to, lb);
        checks++; if (to || bus.grant !== 2'b01) begin $display("FAIL to_grant: got %b want 01", bus.grant); errors++; end
        bus.req = 2'b11;
        wait_for(1, 40, n, to, lb);
        checks++; if (to || n !== TO + 1) begin $display("FAIL to_latency: got %0d want %0d", n, TO + 1); errors++; end
        checks++; if (bus.err !== 2'b01) begin $display("FAIL to_err: got %b want 01", bus.err); errors++; end
        checks++; if (bus.done !== 2'b00) begin $display("FAIL to_no_done: got %b want 00", bus.done); errors++; end
        $display("job: owner=01 aborted err=%b cycles=%0d", bus.err, n);
        wait_for(0, 10, n, to, lb);
        checks++; if (to || bus.grant !== 2'b10) begin $display("FAIL to_next_grant: got %b want 10", bus.grant); errors++; end
        eng_mode = 0;
        apply_reset();
    endtask
`endif

    initial begin
        bus.req = 2'b00;
        bus.req_degp0 = '0; bus.req_degp1 = '0;
        bus.bank_data0 = '0; bus.bank_data1 = '0;
        test_reset();
        test_single_job();
        test_round_robin();
        test_bank_mux();
        test_no_busy();
        test_reset_mid_run();
`ifdef HASH_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
